branch_predict_ctrl: RTL
========================

Name: branch_predict_ctrl

Overview:
Sequences the branch history table (BHT) between the fetch stage (lookups) and the execute stage (resolutions). Each accepted lookup issues a BHT read. The returned prediction is recorded with its index in an in-order in-flight queue. Each resolution pops the queue, writes the outcome back to the BHT, detects mispredictions, flushes younger in-flight branches and stalls lookups for a fixed refill window. It also keeps saturating branch and mispredict counters.

Parameters:
LOWER, 5, BHT index width (PC low bits)
DEPTH, 4, in-flight queue entries (power of two, >=2)
FLUSH_CYC, 3, lookup-blocked cycles after a mispredict (>=1)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
lookup_valid  in  1  fetch requests prediction
lookup_idx  in  LOWER  BHT index of branch PC
lookup_ready  out  1  lookup accepted when valid&ready
pred_valid  out  1  prediction returned (1-cycle pulse)
pred_taken  out  1  predicted direction
resolve_valid  in  1  execute resolves oldest in-flight branch
resolve_taken  in  1  actual outcome (taken or jumped)
mispredict  out  1  1-cycle flush pulse
bht_rd_en  out  1  BHT read strobe
bht_rd_addr  out  LOWER  BHT read index
bht_pred  in  1  BHT prediction, valid cycle after bht_rd_en
bht_wr_en  out  1  BHT update strobe
bht_wr_addr  out  LOWER  BHT update index
bht_wr_taken  out  1  outcome written to BHT
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredictions, saturating
err_underflow  out  1  sticky: resolve with empty queue

Behaviour:
- Reset (async on arst_n low, released synchronously):
  - State RUN; queue empty; lookup_pend=0.
  - All outputs 0, except lookup_ready, which follows its equation.
  - Counters 0; err_underflow 0.
- FSM states are RUN and FLUSH:
  - RUN -> FLUSH on a mispredict; load flush counter with FLUSH_CYC.
  - In FLUSH, decrement the counter each cycle; go to RUN the cycle it reaches 1.
  - A further mispredict is impossible in FLUSH (queue empty; resolve underflows).
- Occupancy = queue count + lookup_pend.
- lookup_ready = (state==RUN) && occupancy<DEPTH && !mispredict_this_cycle.
  - mispredict_this_cycle is combinational from resolve_valid, resolve_taken and the head entry.
  - lookup_ready must not depend on lookup_valid.
- Lookup accepted in cycle N:
  - bht_rd_en=1 and bht_rd_addr=lookup_idx in N (combinational).
  - lookup_pend set for N+1.
- Cycle N+1:
  - pred_valid=1 and pred_taken=bht_pred (combinational pass-through).
  - Push {idx, bht_pred} at the queue tail.
  - Back-to-back lookups every cycle are allowed.
- Resolve in cycle M with queue non-empty:
  - bht_wr_en=1, bht_wr_addr=head.idx, bht_wr_taken=resolve_taken, all in M.
  - Pop the head; branch_cnt+1 (saturates at all-ones).
- If the head is still pending (push and resolve in the same cycle with queue empty):
  - The pending entry is the head; compare against bht_pred.
  - The push is consumed; count stays 0.
- Mispredict (resolve_taken != head prediction):
  - mispredict=1 in M; mispred_cnt+1 (saturating).
  - At M+1 the queue is cleared and lookup_pend cleared.
  - Any pred_valid in M+1 is suppressed (forced 0).
- Resolve with empty queue and no pending entry:
  - No BHT write, no count change.
  - err_underflow set until reset.
- Simultaneous push and pop with no mispredict: count unchanged; pointers wrap modulo DEPTH.
- BHT read and write in the same cycle are both issued; the BHT resolves ordering itself (read returns the pre-update state).
- Reset mid-operation discards all in-flight entries, any pending lookup and the FLUSH state immediately.

Test Plan:
- Reset, then lookup idx=5 with bht_pred=1 -> bht_rd_en/addr=5 in N; pred_valid=1, pred_taken=1 in N+1; occupancy 1.
- Four back-to-back lookups (DEPTH=4), no resolves -> lookup_ready=0 from the cycle after the 4th accept. A resolve with matching outcome -> ready returns next cycle; bht_wr_addr equals the oldest idx.
- Queue holds idx {3,7}, predictions {0,1}; resolve_taken=1 -> mispredict pulse, bht_wr_addr=3, bht_wr_taken=1, mispred_cnt=1. Queue is empty next cycle and lookup_ready=0 for exactly 3 cycles, then 1.
- Lookup accepted at N and resolve at N+1 with queue empty -> compare against bht_pred at N+1, write idx, count stays 0, no underflow.
- Resolve with empty queue -> no bht_wr_en; err_underflow=1 and held; branch_cnt unchanged.
- Pre-load branch_cnt near saturation (CNT_W=4), apply 20 resolves -> branch_cnt stays 15. Assert arst_n low during FLUSH -> all state cleared and lookup_ready=1 after release.

Source files
------------

// File: rtl/branch_predict_ctrl_if.sv
// ============================================================================
// Module   : branch_predict_ctrl_if
// Brief    : Fetch, execute, BHT and status signals of branch_predict_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predict_ctrl_if #(
  parameter int LOWER = 5,
  parameter int CNT_W = 16
);
  logic             lookup_valid;
  logic [LOWER-1:0] lookup_idx;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             mispredict;
  logic             bht_rd_en;
  logic [LOWER-1:0] bht_rd_addr;
  logic             bht_pred;
  logic             bht_wr_en;
  logic [LOWER-1:0] bht_wr_addr;
  logic             bht_wr_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             err_underflow;

  // Controller view
  modport slave (
    input  lookup_valid, lookup_idx, resolve_valid, resolve_taken, bht_pred,
    output lookup_ready, pred_valid, pred_taken, mispredict,
    output bht_rd_en, bht_rd_addr, bht_wr_en, bht_wr_addr, bht_wr_taken,
    output branch_cnt, mispred_cnt, err_underflow
  );

  // Pipeline / BHT view
  modport master (
    output lookup_valid, lookup_idx, resolve_valid, resolve_taken, bht_pred,
    input  lookup_ready, pred_valid, pred_taken, mispredict,
    input  bht_rd_en, bht_rd_addr, bht_wr_en, bht_wr_addr, bht_wr_taken,
    input  branch_cnt, mispred_cnt, err_underflow
  );
endinterface

`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
// ============================================================================
// Module   : branch_predict_ctrl
// Brief    : BHT sequencer: lookups, in-order in-flight queue, resolution,
//            mispredict flush window and saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_ctrl #(
  parameter int LOWER     = 5,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  wire logic              clk,
  input  wire logic              arst_n,
  branch_predict_ctrl_if.slave   bus_io
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_FC_W  = $clog2(FLUSH_CYC + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [c_FC_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic [LOWER-1:0]     idx_mem_q [DEPTH];
  logic [DEPTH-1:0]     pred_mem_q;
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W:0]     count_q, count_d;
  logic                 pend_q, pend_d;
  logic [LOWER-1:0]     pend_idx_q, pend_idx_d;

  logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;
  logic                 err_q, err_d;

  logic                 w_have_head;
  logic                 w_head_pending;
  logic [LOWER-1:0]     w_head_idx;
  logic                 w_head_pred;
  logic                 w_resolve_hit;
  logic                 w_mispredict;
  logic [c_PTR_W:0]     w_occupancy;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  // A prediction still in its return cycle is the head when the queue is empty
  assign w_head_pending = pend_q && (count_q == '0);
  assign w_have_head    = pend_q || (count_q != '0);
  assign w_head_idx     = w_head_pending ? pend_idx_q : idx_mem_q[rd_ptr_q];
  assign w_head_pred    = w_head_pending ? bus_io.bht_pred : pred_mem_q[rd_ptr_q];

  assign w_resolve_hit  = bus_io.resolve_valid && w_have_head;
  assign w_mispredict   = w_resolve_hit && (bus_io.resolve_taken != w_head_pred);

  assign w_occupancy    = count_q + (c_PTR_W + 1)'(pend_q);
  assign w_ready        = (state_q == ST_RUN) &&
                          (w_occupancy < (c_PTR_W + 1)'(DEPTH)) &&
                          !w_mispredict;
  assign w_accept       = bus_io.lookup_valid && w_ready;

  // A pending entry resolved in its own return cycle is consumed, never stored
  assign w_push         = pend_q && !(w_head_pending && w_resolve_hit);
  assign w_pop          = w_resolve_hit && !w_head_pending;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (w_mispredict) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = c_FC_W'(FLUSH_CYC);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == c_FC_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - c_FC_W'(1);
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + c_PTR_W'(w_push);
    rd_ptr_d   = rd_ptr_q + c_PTR_W'(w_pop);
    count_d    = count_q + (c_PTR_W + 1)'(w_push) - (c_PTR_W + 1)'(w_pop);
    pend_d     = w_accept;
    pend_idx_d = w_accept ? bus_io.lookup_idx : pend_idx_q;
    if (w_mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pend_d   = 1'b0;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    err_d         = err_q;
    if (w_resolve_hit && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (w_mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
    if (bus_io.resolve_valid && !w_have_head) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pend_q        <= 1'b0;
      pend_idx_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      pend_idx_q    <= pend_idx_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      err_q         <= err_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (w_push) begin
      idx_mem_q[wr_ptr_q]  <= pend_idx_q;
      pred_mem_q[wr_ptr_q] <= bus_io.bht_pred;
    end
  end

  assign bus_io.lookup_ready  = w_ready;
  assign bus_io.pred_valid    = pend_q;
  assign bus_io.pred_taken    = pend_q && bus_io.bht_pred;
  assign bus_io.mispredict    = w_mispredict;
  assign bus_io.bht_rd_en     = w_accept;
  assign bus_io.bht_rd_addr   = w_accept ? bus_io.lookup_idx : '0;
  assign bus_io.bht_wr_en     = w_resolve_hit;
  assign bus_io.bht_wr_addr   = w_resolve_hit ? w_head_idx : '0;
  assign bus_io.bht_wr_taken  = w_resolve_hit && bus_io.resolve_taken;
  assign bus_io.branch_cnt    = branch_cnt_q;
  assign bus_io.mispred_cnt   = mispred_cnt_q;
  assign bus_io.err_underflow = err_q;

endmodule

`default_nettype wire
